// File: rtl/mux_vec_seq_if.sv
// Signals between the mux test sequencer (master) and the bench/mux side (slave).
interface mux_vec_seq_if;
    logic       start;
    logic       abort;
    logic       mux_out;
    logic       select;
    logic       in1;
    logic       in2;
    logic       busy;
    logic       done;
    logic [2:0] vec_idx;
    logic [3:0] err_cnt;

    modport master (
        input  start, abort, mux_out,
        output select, in1, in2, busy, done, vec_idx, err_cnt
    );

    modport slave (
        output start, abort, mux_out,
        input  select, in1, in2, busy, done, vec_idx, err_cnt
    );
endinterface

// File: rtl/mux_vec_seq.sv
// Sequencer that walks 3-bit vectors {select,in1,in2} through a 2:1 mux under test.
// Define MUX_VEC_SEQ_CHECK_EN to compile in the mux_out compare and err_cnt counter.
module mux_vec_seq #(
    parameter int HOLD_CYCLES = 5,
    parameter int NUM_VEC     = 8
) (
    input logic           clk,
    input logic           rst,
    mux_vec_seq_if.master bus
);
    // state | meaning
    // IDLE  | outputs 000, waiting for start
    // APPLY | vector vec_idx driven for HOLD_CYCLES cycles, compared at the last one
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] VEC_LAST  = 3'(NUM_VEC - 1);

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] err_q, err_d;
    logic       mismatch;
    logic [2:0] pins;

`ifdef MUX_VEC_SEQ_CHECK_EN
    logic exp_out;
    assign exp_out  = vec_q[2] ? vec_q[0] : vec_q[1];
    assign mismatch = (bus.mux_out != exp_out);
`else
    // err_q stays at its reset/cleared value of zero when checking is compiled out
    assign mismatch = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        vec_d   = vec_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = APPLY;
                    hold_d  = 8'd0;
                    vec_d   = 3'd0;
                    err_d   = 4'd0;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    if (mismatch && (err_q != 4'hF)) begin
                        err_d = err_q + 4'd1;
                    end
                    hold_d = 8'd0;
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            vec_q   <= 3'd0;
            err_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
        end
    end

    assign pins        = (state_q == APPLY) ? vec_q : 3'b000;
    assign bus.select  = pins[2];
    assign bus.in1     = pins[1];
    assign bus.in2     = pins[0];
    assign bus.busy    = (state_q == APPLY);
    assign bus.done    = (state_q == DONE);
    assign bus.vec_idx = vec_q;
    assign bus.err_cnt = err_q;
endmodule

// File: doc/mux_vec_seq.md
MUX_VEC_SEQ -- requirements
Module: mux_vec_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 5, meaning clock cycles each vector is held (legal 2..255).
REQ-002 SHALL have parameter NUM_VEC, default 8, meaning number of vectors per run (legal 1..8).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 abort  input  1  cancel run, sampled in APPLY.
REQ-007 mux_out  input  1  output of downstream 2:1 mux under test.
REQ-008 select  output  1  mux select; 0 picks in1, 1 picks in2.
REQ-009 in1  output  1  mux data input 1.
REQ-010 in2  output  1  mux data input 2.
REQ-011 busy  output  1  high while in APPLY.
REQ-012 done  output  1  one-cycle pulse at run completion.
REQ-013 vec_idx  output  3  index of vector currently driven.
REQ-014 err_cnt  output  4  mismatches in current/last run.

Function
REQ-015 SHALL implement states IDLE, APPLY, DONE, all registered.
REQ-016 SHALL drive {select,in1,in2} = vec_idx in APPLY and 3'b000 in IDLE/DONE.
REQ-017 IDLE with start=1 at an edge SHALL move to APPLY, vec_idx=0, hold count=0, err_cnt=0.
REQ-018 SHALL hold each vector exactly HOLD_CYCLES cycles, hold counter 0..HOLD_CYCLES-1.
REQ-019 SHALL compare mux_out against expected (select ? in2 : in1) at the edge ending the last hold cycle only; mismatch increments err_cnt by 1.
REQ-020 After the compare, vec_idx < NUM_VEC-1 SHALL increment vec_idx, clear hold count, stay in APPLY; vec_idx = NUM_VEC-1 SHALL move to DONE.
REQ-021 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE; err_cnt and vec_idx hold until next accepted start.
REQ-022 Run length SHALL be NUM_VEC*HOLD_CYCLES APPLY cycles; defaults give done in the 41st cycle after the start edge.
REQ-023 start outside IDLE SHALL be ignored; start in the DONE cycle is ignored.
REQ-024 abort=1 in APPLY SHALL go to IDLE next edge, drive 000, busy=0, no done pulse, err_cnt retained; the compare of that edge is skipped.
REQ-025 abort and rst together: rst wins; abort outside APPLY ignored.
REQ-026 err_cnt cannot exceed NUM_VEC (max 8) and SHALL never wrap.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, select=in1=in2=0, busy=0, done=0, vec_idx=0, err_cnt=0, hold count=0, from any state including mid-run.
REQ-028 First start honoured SHALL be the first edge with rst=0 and start=1.

Configuration
REQ-029 Macro MUX_VEC_SEQ_CHECK_EN SHALL compile in the mux_out compare and err_cnt counter.
REQ-030 Without MUX_VEC_SEQ_CHECK_EN, err_cnt SHALL be tied to 0, mux_out ignored, all sequencing/timing unchanged.

Verification
REQ-031 Defaults, ideal mux model, start pulse -> vectors 000..111 each 5 cycles, busy 40 cycles, done in cycle 41, err_cnt=0.
REQ-032 mux_out stuck 0 -> mismatches on 010,011,101,111, err_cnt=4 at done.
REQ-033 mux_out inverted ideal -> err_cnt=8; then second start -> err_cnt cleared to 0 on accept.
REQ-034 start re-pulsed at cycle 7, abort at cycle 12 -> start ignored, IDLE next edge, outputs 000, busy=0, no done, err_cnt retained.
REQ-035 rst asserted at cycle 20 of a run -> all outputs at reset values next edge; next start restarts from vec 0.
REQ-036 HOLD_CYCLES=2, NUM_VEC=1, macro undefined, mux_out stuck 0 -> 2 APPLY cycles, done in cycle 3, err_cnt=0.
